fetch_prefetch_queue: RTL and testbench

- Parametrised successor to the single-register fetch stage.
- Issues in-order instruction requests to a variable-latency instruction memory using a valid/ready handshake.
- Buffers returned instructions with their PCs in a QDEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- A branch redirect flushes the FIFO and discards responses that are still in flight.

---
 rtl/fetch_prefetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: in-order instruction prefetcher.
// Issues fetch requests to a variable-latency instruction memory and keeps
// the returned instructions and their PCs in a small FIFO for decode.
// Issue uses credits: count + inflight never exceeds QDEPTH, so the FIFO
// always has room for every response that is still outstanding.
// After a redirect, the responses still in flight are counted off and
// dropped through the discard counter.
module fetch_prefetch_queue #(
    parameter int              XLEN        = 32,
    parameter int              ILEN        = 32,
    parameter int              QDEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            dec_ready,
    output logic            dec_valid,
    output logic [ILEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(QDEPTH);
    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(INSTR_BYTES);

    // FIFO storage. The head is read combinationally, so the outputs follow the head entry in the same cycle.
    logic [ILEN-1:0] instr_mem [QDEPTH];
    logic [XLEN-1:0] pc_mem    [QDEPTH];

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic [CW-1:0]   discard_reg, discard_next;

    logic [CW:0]     credit_sum;
    logic            req_fire;
    logic            resp_take;
    logic            resp_drop;
    logic            push;
    logic            pop;

    // Handshake decode: credit check, response accept/drop, push/pop and decode outputs.
    always_comb begin
        credit_sum     = {1'b0, count_reg} + {1'b0, inflight_reg};
        imem_req_valid = !rst && !PCSrcE && (credit_sum < CREDIT_LIMIT);
        imem_req_addr  = fetch_pc_reg;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp_take      = !rst && imem_resp_valid && (inflight_reg != '0);
        resp_drop      = resp_take && (discard_reg != '0);
        // A response that arrives in a redirect cycle is dropped, because the FIFO is cleared anyway.
        push           = resp_take && (discard_reg == '0) && !PCSrcE;
        dec_valid      = !rst && !PCSrcE && (count_reg != '0);
        pop            = dec_valid && dec_ready;
        InstrD         = '0;
        PCD            = '0;
        PCPlus4D       = '0;
        if (dec_valid) begin
            InstrD   = instr_mem[rd_ptr_reg];
            PCD      = pc_mem[rd_ptr_reg];
            PCPlus4D = pc_mem[rd_ptr_reg] + PC_STEP;
        end
    end

    // Next-state computation for PCs, pointers and the three counters.
    always_comb begin
        inflight_next = inflight_reg + CW'(req_fire) - CW'(resp_take);
        fetch_pc_next = req_fire ? fetch_pc_reg + PC_STEP : fetch_pc_reg;
        resp_pc_next  = push ? resp_pc_reg + PC_STEP : resp_pc_reg;
        wr_ptr_next   = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next   = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        count_next    = count_reg + CW'(push) - CW'(pop);
        discard_next  = discard_reg - CW'(resp_drop);
        if (PCSrcE) begin
            // Everything still outstanding after this edge belongs to the old path.
            fetch_pc_next = PCTargetE;
            resp_pc_next  = PCTargetE;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            discard_next  = inflight_next;
        end
    end

    // State registers with synchronous reset; reset overrides redirects and responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            discard_reg  <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            discard_reg  <= discard_next;
        end
    end

    // FIFO write: the response is stored together with the PC it belongs to.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_resp_data;
            pc_mem[wr_ptr_reg]    <= resp_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue: randomized memory/decode/redirect
// traffic checked every cycle against a queue-based reference model.
module tb_fetch_prefetch_queue;

    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    fetch_prefetch_queue #(
        .XLEN(32), .ILEN(32), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC), .INSTR_BYTES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .dec_ready(dec_ready), .dec_valid(dec_valid),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding requests, decoded-queue contents, memory pipe.
    typedef struct { logic [31:0] pc; bit disc; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    req_t        infl_q[$];
    ent_t        fifo_q[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc;
    int          cyc;
    int          pops;
    int          stale_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs.
    int lat_min, lat_max, p_rr, p_dr, p_redir, p_resp;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic do_cycle(input bit rst_v, input bit force_stale);
        bit          redir, dr, rr, from_mem, exp_req, exp_dec;
        logic [31:0] target;
        int          lat;
        mem_t        m;
        req_t        e;
        ent_t        head;

        redir  = !rst_v && ($urandom_range(99) < p_redir);
        target = $urandom & 32'hFFFF_FFFC;
        dr     = $urandom_range(99) < p_dr;
        rr     = $urandom_range(99) < p_rr;
        from_mem = !rst_v && !force_stale && mem_q.size() > 0 && mem_q[0].due <= cyc
                   && ($urandom_range(99) < p_resp);

        rst             = rst_v;
        PCSrcE          = redir;
        PCTargetE       = target;
        dec_ready       = dr;
        imem_req_ready  = rr;
        imem_resp_valid = from_mem || force_stale;
        imem_resp_data  = from_mem ? mem_data(mem_q[0].addr) : $urandom;
        #1;

        exp_req = !rst_v && !redir && (fifo_q.size() + infl_q.size() < QDEPTH);
        exp_dec = !rst_v && !redir && (fifo_q.size() != 0);
        head.instr = '0;
        head.pc    = '0;
        if (exp_dec) head = fifo_q[0];

        check("req_valid", 64'(imem_req_valid), 64'(exp_req));
        if (exp_req) check("req_addr", 64'(imem_req_addr), 64'(m_pc));
        check("dec_valid", 64'(dec_valid), 64'(exp_dec));
        check("InstrD", 64'(InstrD), 64'(head.instr));
        check("PCD", 64'(PCD), 64'(head.pc));
        check("PCPlus4D", 64'(PCPlus4D), exp_dec ? 64'(head.pc + 32'd4) : 64'd0);
        $display("cyc %0d rst=%0d redir=%0d req=%0d addr=%h dec=%0d pc=%h", cyc, rst_v, redir,
                 imem_req_valid, imem_req_addr, dec_valid, PCD);

        if (rst_v) begin
            fifo_q.delete();
            infl_q.delete();
            mem_q.delete();
            m_pc = RESET_PC;
        end else begin
            if (imem_resp_valid) begin
                if (infl_q.size() == 0) begin
                    stale_cnt++;
                    $display("note: response with nothing outstanding at cycle %0d (protocol error, ignored)", cyc);
                end else begin
                    e = infl_q.pop_front();
                    if (!e.disc) fifo_q.push_back('{instr: imem_resp_data, pc: e.pc});
                end
            end
            if (from_mem) void'(mem_q.pop_front());
            if (exp_dec && dr) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            if (exp_req && rr) begin
                infl_q.push_back('{pc: m_pc, disc: 1'b0});
                lat   = $urandom_range(lat_max, lat_min);
                m.addr = m_pc;
                m.due  = cyc + lat;
                if (mem_q.size() > 0 && mem_q[$].due > m.due) m.due = mem_q[$].due;
                mem_q.push_back(m);
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                fifo_q.delete();
                foreach (infl_q[i]) infl_q[i].disc = 1'b1;
                m_pc = target;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rr, input int dr,
                             input int rd, input int rs);
        lat_min = lmin; lat_max = lmax; p_rr = rr; p_dr = dr; p_redir = rd; p_resp = rs;
    endtask

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; dec_ready = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        cyc = 0; pops = 0; stale_cnt = 0; m_pc = RESET_PC;
        set_knobs(1, 1, 100, 100, 0, 100);
        @(posedge clk);
        #1;

        // Reset: all outputs zero.
        do_cycle(1'b1, 1'b0);
        do_cycle(1'b1, 1'b0);

        // Streaming at 1-cycle latency: one instruction per cycle after 2-cycle startup.
        pops = 0;
        for (int i = 0; i < 40; i++) do_cycle(1'b0, 1'b0);
        check("stream_pops", 64'(pops), 64'd38);

        // Decode stalled: credits stop issue once the queue fills, then drain.
        set_knobs(1, 1, 100, 0, 0, 100);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0);
        set_knobs(1, 1, 100, 100, 0, 100);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0);

        // Memory backpressure.
        set_knobs(1, 2, 30, 100, 0, 100);
        for (int i = 0; i < 30; i++) do_cycle(1'b0, 1'b0);

        // Longer latency with redirects.
        set_knobs(3, 3, 100, 100, 8, 100);
        for (int i = 0; i < 200; i++) do_cycle(1'b0, 1'b0);

        // Fully random traffic.
        set_knobs(1, 5, 70, 60, 6, 75);
        for (int i = 0; i < 1500; i++) do_cycle(1'b0, 1'b0);

        // Mid-stream reset, then a stale response that must be ignored.
        do_cycle(1'b1, 1'b0);
        do_cycle(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) do_cycle(1'b0, 1'b0);
        check("stale_seen", 64'(stale_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
